// File: rtl/mux_scan_if.sv
// mux_scan_if -- bus bundle for the mux_scan channel multiplexer.
//
// Parameters: WIDTH (bits per channel), CHANNELS (number of channels).
// SEL_W is derived from CHANNELS and is not meant to be overridden.
//
// Signals:
//   in_bus    CHANNELS*WIDTH  channel i on bits [i*WIDTH +: WIDTH]
//   sel       SEL_W           manual channel select
//   mode      1               0 = manual, 1 = scan
//   en        1               block enable
//   ch_mask   CHANNELS        per-channel enable (only with MUX_SCAN_MASK_EN)
//   out       WIDTH           registered selected data
//   out_chan  SEL_W           channel index currently on out
//   out_valid 1               out/out_chan hold a legal sample
//   wrap      1               one-cycle pulse on scan wrap-around
//
// Modports: master drives the inputs (source/consumer side), slave is the mux.
// Optional feature macro: MUX_SCAN_MASK_EN.

interface mux_scan_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
);
   localparam int SEL_W = $clog2(CHANNELS);

   logic [CHANNELS*WIDTH-1:0] in_bus;
   logic [SEL_W-1:0]          sel;
   logic                      mode;
   logic                      en;
`ifdef MUX_SCAN_MASK_EN
   logic [CHANNELS-1:0]       ch_mask;
`endif
   logic [WIDTH-1:0]          out;
   logic [SEL_W-1:0]          out_chan;
   logic                      out_valid;
   logic                      wrap;

   modport master (
      output in_bus, sel, mode, en,
`ifdef MUX_SCAN_MASK_EN
      output ch_mask,
`endif
      input  out, out_chan, out_valid, wrap
   );

   modport slave (
      input  in_bus, sel, mode, en,
`ifdef MUX_SCAN_MASK_EN
      input  ch_mask,
`endif
      output out, out_chan, out_valid, wrap
   );
endinterface

// File: rtl/mux_scan.sv
// mux_scan -- registered N-channel x W-bit multiplexer with a manual-select
// mode and an automatic round-robin scan mode with programmable dwell.
//
// Parameters: WIDTH (data width), CHANNELS (2..16), DWELL (cycles per channel
// in scan mode, >= 1). SEL_W = ceil(log2(CHANNELS)) is derived.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    mux_scan_if.slave: in_bus, sel, mode, en, [ch_mask] in;
//          out, out_chan, out_valid, wrap out (all registered)
//
// Optional feature macro: MUX_SCAN_MASK_EN adds ch_mask; scan then only visits
// enabled channels and manual selection of a masked channel is rejected.
// Without it every channel counts as enabled.

module mux_scan #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int DWELL    = 4
) (
   input logic       clk,
   input logic       rst_n,
   mux_scan_if.slave bus
);
   localparam int SEL_W = $clog2(CHANNELS);
   localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

   typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

   state_t                    state;
   logic [SEL_W-1:0]          p;
   logic [DW_W-1:0]           d;
   logic [WIDTH-1:0]          out_r;
   logic [SEL_W-1:0]          out_chan_r;
   logic                      out_valid_r;
   logic                      wrap_r;

   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       mask;
   logic                      sel_ok;
   logic                      any_en;
   logic                      advance;
   logic [SEL_W-1:0]          first_ch;
   logic [SEL_W-1:0]          step_ch;

   assign in_data = bus.in_bus;

`ifdef MUX_SCAN_MASK_EN
   assign mask = bus.ch_mask;
`else
   assign mask = '1;
`endif

   // Selects channel idx from the packed bus; out-of-range indices give 0
   // and are never registered because callers qualify them first.
   function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] data,
                                             input logic [SEL_W-1:0] idx);
      pick = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (idx == SEL_W'(i)) pick = data[i*WIDTH +: WIDTH];
      end
   endfunction

   // True when idx names an existing channel that is enabled in m.
   function automatic logic is_enabled(input logic [CHANNELS-1:0] m,
                                       input logic [SEL_W-1:0] idx);
      is_enabled = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (idx == SEL_W'(i) && m[i]) is_enabled = 1'b1;
      end
   endfunction

   // Lowest enabled channel, used as the scan start point.
   function automatic logic [SEL_W-1:0] lowest(input logic [CHANNELS-1:0] m);
      lowest = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (m[i]) lowest = SEL_W'(i);
      end
   endfunction

   // Next enabled channel strictly after c, ascending with wrap. If c is the
   // only enabled channel the search comes back round to c itself.
   function automatic logic [SEL_W-1:0] next_ch(input logic [CHANNELS-1:0] m,
                                                input logic [SEL_W-1:0] c);
      logic found;
      int   idx;
      next_ch = c;
      found   = 1'b0;
      for (int k = 1; k <= CHANNELS; k++) begin
         idx = (int'(c) + k) % CHANNELS;
         if (!found && m[idx]) begin
            next_ch = SEL_W'(idx);
            found   = 1'b1;
         end
      end
   endfunction

   assign sel_ok   = is_enabled(mask, bus.sel);
   assign any_en   = |mask;
   assign first_ch = lowest(mask);
   assign step_ch  = next_ch(mask, p);
   // Leave the current channel at the end of its dwell, or at once if it
   // has just been masked off.
   assign advance  = !is_enabled(mask, p) || (d == DW_W'(DWELL - 1));

   // Single-process FSM: state, scan pointer/dwell counter and all outputs
   // are registered together. en/mode pick the next state every cycle;
   // leaving SCAN clears p and d so the next scan entry always restarts.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         p           <= '0;
         d           <= '0;
         out_r       <= '0;
         out_chan_r  <= '0;
         out_valid_r <= 1'b0;
         wrap_r      <= 1'b0;
      end else if (!bus.en) begin
         state       <= IDLE;
         p           <= '0;
         d           <= '0;
         out_valid_r <= 1'b0;
         wrap_r      <= 1'b0;
      end else if (!bus.mode) begin
         state  <= MANUAL;
         p      <= '0;
         d      <= '0;
         wrap_r <= 1'b0;
         if (sel_ok) begin
            out_r       <= pick(in_data, bus.sel);
            out_chan_r  <= bus.sel;
            out_valid_r <= 1'b1;
         end else begin
            out_valid_r <= 1'b0;
         end
      end else begin
         state <= SCAN;
         if (!any_en) begin
            // Nothing to scan: hold the last sample and freeze the dwell.
            out_valid_r <= 1'b0;
            wrap_r      <= 1'b0;
            if (state != SCAN) begin
               p <= '0;
               d <= '0;
            end
         end else if (state != SCAN) begin
            p           <= first_ch;
            d           <= '0;
            out_r       <= pick(in_data, first_ch);
            out_chan_r  <= first_ch;
            out_valid_r <= 1'b1;
            wrap_r      <= 1'b0;
         end else if (advance) begin
            p           <= step_ch;
            d           <= '0;
            out_r       <= pick(in_data, step_ch);
            out_chan_r  <= step_ch;
            out_valid_r <= 1'b1;
            wrap_r      <= (step_ch <= p);
         end else begin
            d           <= d + 1'b1;
            out_r       <= pick(in_data, p);
            out_chan_r  <= p;
            out_valid_r <= 1'b1;
            wrap_r      <= 1'b0;
         end
      end
   end

   assign bus.out       = out_r;
   assign bus.out_chan  = out_chan_r;
   assign bus.out_valid = out_valid_r;
   assign bus.wrap      = wrap_r;

endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan -- scoreboard bench for mux_scan.
//
// Three instances cover the interesting shapes:
//   A: WIDTH=8, CHANNELS=4, DWELL=2  (scan sequence, reset, mode switch)
//   B: WIDTH=8, CHANNELS=5, DWELL=1  (out-of-range sel, fast scan, mask)
//   C: WIDTH=1, CHANNELS=4, DWELL=4  (single-bit manual select)
// Stimulus pushes the expected post-edge outputs into a queue; a monitor on
// the falling edge pops and compares them. Honours MUX_SCAN_MASK_EN.

module tb_mux_scan;

   logic clk;
   logic rst_n;

   typedef struct {
      int         dut;
      int         id;
      logic [7:0] out;
      logic [3:0] chan;
      logic       valid;
      logic       wrap;
   } exp_t;

   exp_t sb[$];
   int   tests_run    = 0;
   int   tests_failed = 0;
   int   item_id      = 0;

   mux_scan_if #(.WIDTH(8), .CHANNELS(4)) if_a ();
   mux_scan_if #(.WIDTH(8), .CHANNELS(5)) if_b ();
   mux_scan_if #(.WIDTH(1), .CHANNELS(4)) if_c ();

   mux_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
   mux_scan #(.WIDTH(8), .CHANNELS(5), .DWELL(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
   mux_scan #(.WIDTH(1), .CHANNELS(4), .DWELL(4)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Waits for the next rising edge and moves just past it, so inputs
   // changed afterwards never race the DUT sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives the control inputs of one instance, then clocks once.
   task automatic applyStimulus(input int dut, input logic en, input logic mode, input int sel);
      case (dut)
         0: begin if_a.en = en; if_a.mode = mode; if_a.sel = 2'(sel); end
         1: begin if_b.en = en; if_b.mode = mode; if_b.sel = 3'(sel); end
         default: begin if_c.en = en; if_c.mode = mode; if_c.sel = 2'(sel); end
      endcase
      tick();
   endtask

   // Queues what the given instance must show after the edge just taken.
   task automatic checkOutput(input int dut, input logic [7:0] eo, input int ec,
                              input logic ev, input logic ew);
      exp_t e;
      e.dut   = dut;
      e.id    = item_id;
      e.out   = eo;
      e.chan  = 4'(ec);
      e.valid = ev;
      e.wrap  = ew;
      item_id++;
      sb.push_back(e);
   endtask

   // Monitor: compares every pending expectation against its instance.
   exp_t       m_e;
   logic [7:0] m_out;
   logic [3:0] m_chan;
   logic       m_valid;
   logic       m_wrap;

   always @(negedge clk) begin
      while (sb.size() > 0) begin
         m_e = sb.pop_front();
         case (m_e.dut)
            0: begin
               m_out = if_a.out; m_chan = {2'b0, if_a.out_chan};
               m_valid = if_a.out_valid; m_wrap = if_a.wrap;
            end
            1: begin
               m_out = if_b.out; m_chan = {1'b0, if_b.out_chan};
               m_valid = if_b.out_valid; m_wrap = if_b.wrap;
            end
            default: begin
               m_out = {7'b0, if_c.out}; m_chan = {2'b0, if_c.out_chan};
               m_valid = if_c.out_valid; m_wrap = if_c.wrap;
            end
         endcase
         tests_run++;
         if (m_out !== m_e.out || m_chan !== m_e.chan ||
             m_valid !== m_e.valid || m_wrap !== m_e.wrap) begin
            tests_failed++;
            $display("[TB] FAIL dut%0d item%0d: got out=%h chan=%0d valid=%b wrap=%b, expected out=%h chan=%0d valid=%b wrap=%b",
                     m_e.dut, m_e.id, m_out, m_chan, m_valid, m_wrap,
                     m_e.out, m_e.chan, m_e.valid, m_e.wrap);
         end
      end
   end

   logic [7:0] scan_out [10] = '{8'h10, 8'h10, 8'h20, 8'h20, 8'h30, 8'h30, 8'h40, 8'h40, 8'h10, 8'h10};
   int         scan_ch  [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
   logic [7:0] b_out    [7]  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h01, 8'h02};
   int         b_ch     [7]  = '{0, 1, 2, 3, 4, 0, 1};

   initial begin
      rst_n = 1'b0;
      if_a.in_bus = '0; if_a.sel = '0; if_a.mode = 1'b0; if_a.en = 1'b0;
      if_b.in_bus = '0; if_b.sel = '0; if_b.mode = 1'b0; if_b.en = 1'b0;
      if_c.in_bus = '0; if_c.sel = '0; if_c.mode = 1'b0; if_c.en = 1'b0;
`ifdef MUX_SCAN_MASK_EN
      if_a.ch_mask = '1;
      if_b.ch_mask = '1;
      if_c.ch_mask = '1;
`endif

      // Reset state on every instance.
      tick();
      checkOutput(0, 8'h00, 0, 1'b0, 1'b0);
      checkOutput(1, 8'h00, 0, 1'b0, 1'b0);
      checkOutput(2, 8'h00, 0, 1'b0, 1'b0);
      rst_n = 1'b1;

      // Single-bit manual select: ch0..3 = 0,1,1,1.
      if_c.in_bus = 4'b1110;
      applyStimulus(2, 1'b1, 1'b0, 0); checkOutput(2, 8'h00, 0, 1'b1, 1'b0);
      applyStimulus(2, 1'b1, 1'b0, 1); checkOutput(2, 8'h01, 1, 1'b1, 1'b0);
      applyStimulus(2, 1'b1, 1'b0, 2); checkOutput(2, 8'h01, 2, 1'b1, 1'b0);
      applyStimulus(2, 1'b1, 1'b0, 3); checkOutput(2, 8'h01, 3, 1'b1, 1'b0);
      // Disabling holds the data but drops valid.
      applyStimulus(2, 1'b0, 1'b0, 3); checkOutput(2, 8'h01, 3, 1'b0, 1'b0);

      // Scan with DWELL=2; wrap only on the ninth sample.
      if_a.in_bus = {8'h40, 8'h30, 8'h20, 8'h10};
      for (int k = 0; k < 10; k++) begin
         applyStimulus(0, 1'b1, 1'b1, 0);
         checkOutput(0, scan_out[k], scan_ch[k], 1'b1, (k == 8) ? 1'b1 : 1'b0);
      end
      applyStimulus(0, 1'b1, 1'b1, 0); checkOutput(0, 8'h20, 1, 1'b1, 1'b0);
      applyStimulus(0, 1'b1, 1'b1, 0); checkOutput(0, 8'h20, 1, 1'b1, 1'b0);
      applyStimulus(0, 1'b1, 1'b1, 0); checkOutput(0, 8'h30, 2, 1'b1, 1'b0);
      applyStimulus(0, 1'b1, 1'b1, 0); checkOutput(0, 8'h30, 2, 1'b1, 1'b0);

      // Reset in the middle of ch2's dwell clears everything.
      rst_n = 1'b0;
      tick();
      checkOutput(0, 8'h00, 0, 1'b0, 1'b0);
      checkOutput(2, 8'h00, 0, 1'b0, 1'b0);
      rst_n = 1'b1;

      // Restart from ch0 with a full dwell; live data change mid-dwell.
      applyStimulus(0, 1'b1, 1'b1, 0); checkOutput(0, 8'h10, 0, 1'b1, 1'b0);
      if_a.in_bus[7:0] = 8'h11;
      applyStimulus(0, 1'b1, 1'b1, 0); checkOutput(0, 8'h11, 0, 1'b1, 1'b0);
      if_a.in_bus[7:0] = 8'h10;
      applyStimulus(0, 1'b1, 1'b1, 0); checkOutput(0, 8'h20, 1, 1'b1, 1'b0);
      applyStimulus(0, 1'b1, 1'b1, 0); checkOutput(0, 8'h20, 1, 1'b1, 1'b0);
      applyStimulus(0, 1'b1, 1'b1, 0); checkOutput(0, 8'h30, 2, 1'b1, 1'b0);
      applyStimulus(0, 1'b1, 1'b1, 0); checkOutput(0, 8'h30, 2, 1'b1, 1'b0);
      applyStimulus(0, 1'b1, 1'b1, 0); checkOutput(0, 8'h40, 3, 1'b1, 1'b0);

      // Scan -> manual sel=1, then back to scan restarting at ch0, no wrap.
      applyStimulus(0, 1'b1, 1'b0, 1); checkOutput(0, 8'h20, 1, 1'b1, 1'b0);
      applyStimulus(0, 1'b1, 1'b1, 1); checkOutput(0, 8'h10, 0, 1'b1, 1'b0);
      applyStimulus(0, 1'b1, 1'b1, 1); checkOutput(0, 8'h10, 0, 1'b1, 1'b0);
      applyStimulus(0, 1'b1, 1'b1, 1); checkOutput(0, 8'h20, 1, 1'b1, 1'b0);

      // Five channels: out-of-range sel holds with valid low.
      if_b.in_bus = {8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
      applyStimulus(1, 1'b1, 1'b0, 2); checkOutput(1, 8'h03, 2, 1'b1, 1'b0);
      applyStimulus(1, 1'b1, 1'b0, 6); checkOutput(1, 8'h03, 2, 1'b0, 1'b0);
      applyStimulus(1, 1'b1, 1'b0, 4); checkOutput(1, 8'h05, 4, 1'b1, 1'b0);
      applyStimulus(1, 1'b1, 1'b0, 5); checkOutput(1, 8'h05, 4, 1'b0, 1'b0);

      // DWELL=1 scan over five channels: new channel every cycle.
      for (int k = 0; k < 7; k++) begin
         applyStimulus(1, 1'b1, 1'b1, 0);
         checkOutput(1, b_out[k], b_ch[k], 1'b1, (k == 5) ? 1'b1 : 1'b0);
      end
      applyStimulus(1, 1'b0, 1'b1, 0); checkOutput(1, 8'h02, 1, 1'b0, 1'b0);

`ifdef MUX_SCAN_MASK_EN
      // Only ch1 and ch3 enabled: 1,3,1,3 with wrap on each later ch1.
      if_b.ch_mask = 5'b01010;
      applyStimulus(1, 1'b1, 1'b1, 0); checkOutput(1, 8'h02, 1, 1'b1, 1'b0);
      applyStimulus(1, 1'b1, 1'b1, 0); checkOutput(1, 8'h04, 3, 1'b1, 1'b0);
      applyStimulus(1, 1'b1, 1'b1, 0); checkOutput(1, 8'h02, 1, 1'b1, 1'b1);
      applyStimulus(1, 1'b1, 1'b1, 0); checkOutput(1, 8'h04, 3, 1'b1, 1'b0);
      applyStimulus(1, 1'b1, 1'b1, 0); checkOutput(1, 8'h02, 1, 1'b1, 1'b1);
      // Empty mask: hold last sample, valid low.
      if_b.ch_mask = 5'b00000;
      applyStimulus(1, 1'b1, 1'b1, 0); checkOutput(1, 8'h02, 1, 1'b0, 1'b0);
      applyStimulus(1, 1'b1, 1'b1, 0); checkOutput(1, 8'h02, 1, 1'b0, 1'b0);
`endif

      repeat (2) @(negedge clk);
      if (sb.size() != 0) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL scoreboard_drain: %0d items left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
